// File: rtl/button_reader.sv
// Pushbutton reader: 2-flop synchronizer, four-state debounce FSM, press/release
// pulses and an 8-bit press counter for the board LEDs.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       BTN,
  input  logic       CLR,
  output logic       LEVEL,
  output logic       PRESS,
  output logic       RELEASE,
  output logic [7:0] COUNT
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  logic          sync1_q;
  logic          btn_s_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [7:0]    count_q, count_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (btn_s_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!btn_s_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HIGH: begin
        if (!btn_s_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (btn_s_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state flop.
  always_comb begin
    press_d   = (state_q == ST_WAIT_HIGH) && (state_d == ST_HIGH);
    release_d = (state_q == ST_WAIT_LOW) && (state_d == ST_LOW);
    level_d   = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
    if (CLR)
      count_d = 8'd0;
    else if (press_d)
      count_d = count_q + 8'd1;
    else
      count_d = count_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q   <= 1'b0;
      btn_s_q   <= 1'b0;
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      sync1_q   <= BTN;
      btn_s_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  assign LEVEL   = level_q;
  assign PRESS   = press_q;
  assign RELEASE = release_q;
  assign COUNT   = count_q;

endmodule
